div_32_16_seq: RTL
==================

DIV_32_16_SEQ -- requirements
Module: div_32_16_seq

Interface
REQ-001 SHALL have parameter DVD_W, default 32, dividend/quotient width; only the default value is supported.
REQ-002 SHALL have parameter DVS_W, default 16, divisor/remainder width; only the default value is supported.
REQ-003 SHALL have port sys_clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1, reset: asynchronous assert, active-low.
REQ-005 SHALL have port start, input, 1, request pulse; sampled only in IDLE.
REQ-006 SHALL have port DVD_NUM, input, 32, signed dividend; sampled with start.
REQ-007 SHALL have port DVS_NUM, input, 16, signed divisor; sampled with start.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when results are valid.
REQ-010 SHALL have port Q_NUM, output, 32, signed quotient; held until the next done.
REQ-011 SHALL have port R_NUM, output, 16, signed remainder; held until the next done.
REQ-012 SHALL have port dz, output, 1, divide-by-zero flag; valid with Q_NUM.
REQ-013 SHALL have port ovf, output, 1, overflow flag; valid with Q_NUM.

Function
REQ-014 SHALL implement states IDLE, CALC, FIX and DONE: IDLE->CALC on start; CALC->FIX after 32 iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-015 SHALL register operands on the edge that samples start in IDLE (edge 0); busy SHALL be high from the cycle after edge 0 through the done cycle inclusive.
REQ-016 SHALL assert done for exactly one cycle, after edge 34 (fixed latency for all operands, including dz and ovf cases).
REQ-017 SHALL ignore start while busy; operands and results SHALL be unaffected.
REQ-018 SHALL convert operands to magnitudes and perform one radix-2 restoring iteration per CALC cycle: a 17-bit partial remainder, one quotient bit per cycle, MSB first.
REQ-019 SHALL, in FIX, negate the quotient if the operand signs differ and negate the remainder if the dividend is negative (truncation toward zero).
REQ-020 SHALL satisfy DVD_NUM == Q_NUM*DVS_NUM + R_NUM with |R_NUM| < |DVS_NUM| for every non-zero divisor, except the ovf case.
REQ-021 SHALL, for DVS_NUM == 0, set dz=1, Q_NUM=0 and R_NUM=DVD_NUM[15:0], while keeping the same latency.
REQ-022 SHALL, for DVD_NUM == 32'h8000_0000 with DVS_NUM == -1, set ovf=1, Q_NUM=32'h8000_0000 and R_NUM=0.
REQ-023 SHALL clear dz and ovf on every normal completion; the flags change only at done.
REQ-024 SHALL accept start in the cycle immediately after done (back-to-back operation).

Reset
REQ-025 SHALL, on sys_rst_n low, immediately force IDLE, busy=0, done=0, Q_NUM=0, R_NUM=0, dz=0, ovf=0 and clear the iteration counter, including mid-CALC; the aborted operation produces no done.
REQ-026 SHALL accept start on the first rising edge after sys_rst_n deasserts.

Structure
REQ-027 SHALL take the widths, the iteration count (32) and the state encodings from shared package div_pkg.
REQ-028 SHALL place a single restoring iteration (shift, trial subtract, select, quotient bit) in combinational sub-module div_step.
REQ-029 SHALL keep the FSM, counter, sign handling and output registers in div_32_16_seq.

Verification
REQ-030 SHALL cover 100 / 7 -> Q_NUM=14, R_NUM=2, dz=0, ovf=0, done 34 cycles after start.
REQ-031 SHALL cover -100 / 7 -> Q_NUM=32'hFFFF_FFF2, R_NUM=16'hFFFE; and 32'h4000_0000 / -32768 -> Q_NUM=32'hFFFF_8000, R_NUM=0.
REQ-032 SHALL cover 1234 / 0 -> dz=1, Q_NUM=0, R_NUM=16'h04D2, done at cycle 34.
REQ-033 SHALL cover 32'h8000_0000 / -1 -> ovf=1, Q_NUM=32'h8000_0000, R_NUM=0.
REQ-034 SHALL cover start pulsed again at cycle 10 with different operands -> ignored, and the first operation's result is unchanged.
REQ-035 SHALL cover sys_rst_n pulsed low at cycle 15 of CALC -> all outputs 0 and no done; then 50 / -3 -> Q_NUM=-16, R_NUM=2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared widths, iteration count, FSM encoding and result payload for the
// 32/16 signed sequential divider.
package div_pkg;

   localparam int unsigned DVD_WIDTH  = 32;
   localparam int unsigned DVS_WIDTH  = 16;
   localparam int unsigned REM_WIDTH  = DVS_WIDTH + 1;
   localparam int unsigned ITER_COUNT = DVD_WIDTH;
   localparam int unsigned CNT_WIDTH  = $clog2(ITER_COUNT);

   localparam logic [DVD_WIDTH-1:0] OVF_DVD = {1'b1, {(DVD_WIDTH-1){1'b0}}};
   localparam logic [DVD_WIDTH-1:0] OVF_QUO = OVF_DVD;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic [DVD_WIDTH-1:0] q;
      logic [DVS_WIDTH-1:0] r;
      logic                 dz;
      logic                 ovf;
   } div_res_t;

   // Two's-complement magnitude; the most negative value maps onto its
   // unsigned magnitude, which still fits in the same width.
   function automatic logic [DVD_WIDTH-1:0] dvd_mag(input logic [DVD_WIDTH-1:0] x);
      return x[DVD_WIDTH-1] ? DVD_WIDTH'(-x) : x;
   endfunction

   function automatic logic [DVS_WIDTH-1:0] dvs_mag(input logic [DVS_WIDTH-1:0] x);
      return x[DVS_WIDTH-1] ? DVS_WIDTH'(-x) : x;
   endfunction

endpackage

// File: rtl/div_32_16_seq_if.sv
// Request/response bundle of the divider, with initiator and target views.
interface div_32_16_seq_if;
   import div_pkg::*;

   logic                 start;
   logic [DVD_WIDTH-1:0] DVD_NUM;
   logic [DVS_WIDTH-1:0] DVS_NUM;
   logic                 busy;
   logic                 done;
   logic [DVD_WIDTH-1:0] Q_NUM;
   logic [DVS_WIDTH-1:0] R_NUM;
   logic                 dz;
   logic                 ovf;

   modport master (
      output start, DVD_NUM, DVS_NUM,
      input  busy, done, Q_NUM, R_NUM, dz, ovf
   );

   modport slave (
      input  start, DVD_NUM, DVS_NUM,
      output busy, done, Q_NUM, R_NUM, dz, ovf
   );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference when it does not borrow.
module div_step
   import div_pkg::*;
(
   input  logic [REM_WIDTH-1:0] rem,
   input  logic                 dvd_bit,
   input  logic [DVS_WIDTH-1:0] dvs,
   output logic [REM_WIDTH-1:0] rem_next,
   output logic                 q_bit
);

   localparam int unsigned DIFF_W = REM_WIDTH + 1;

   logic [DIFF_W-1:0] shifted;
   logic [DIFF_W-1:0] diff;

   // The partial remainder stays below the divisor, so its top bit is zero and
   // the extra difference bit acts purely as the borrow.
   always_comb begin
      shifted  = {rem, dvd_bit};
      diff     = shifted - DIFF_W'(dvs);
      q_bit    = ~diff[DIFF_W-1];
      rem_next = q_bit ? diff[REM_WIDTH-1:0] : shifted[REM_WIDTH-1:0];
   end

endmodule

// File: rtl/div_32_16_seq.sv
// Signed 32/16 sequential divider: one quotient bit per cycle, fixed 34-cycle
// latency from the start edge to the done pulse, truncation toward zero.
module div_32_16_seq
   import div_pkg::*;
#(
   parameter int unsigned DVD_W = DVD_WIDTH,
   parameter int unsigned DVS_W = DVS_WIDTH
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             start,
   input  logic [DVD_W-1:0] DVD_NUM,
   input  logic [DVS_W-1:0] DVS_NUM,
   output logic             busy,
   output logic             done,
   output logic [DVD_W-1:0] Q_NUM,
   output logic [DVS_W-1:0] R_NUM,
   output logic             dz,
   output logic             ovf
);

   state_t               state_q;
   state_t               state_d;
   logic                 accept;
   logic                 calc_en;
   logic                 fix_en;
   logic                 fin_en;

   logic [CNT_WIDTH-1:0] cnt_q;
   logic [DVD_W-1:0]     dvd_sh_q;
   logic [DVS_W-1:0]     dvs_mag_q;
   logic [REM_WIDTH-1:0] rem_q;
   logic [DVD_W-1:0]     quo_q;
   logic [DVS_W-1:0]     dvd_lo_q;
   logic                 neg_q_q;
   logic                 neg_r_q;
   logic                 dz_q;
   logic                 ovf_q;
   div_res_t             res_q;
   div_res_t             fix_res;

   logic [REM_WIDTH-1:0] step_rem;
   logic                 step_q;

   div_step u_step (
      .rem      (rem_q),
      .dvd_bit  (dvd_sh_q[DVD_W-1]),
      .dvs      (dvs_mag_q),
      .rem_next (step_rem),
      .q_bit    (step_q)
   );

   // State register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and per-state strobes; busy also covers the done cycle, which
   // keeps a start coinciding with done from being taken.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      calc_en = 1'b0;
      fix_en  = 1'b0;
      fin_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !busy) begin
               accept  = 1'b1;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            calc_en = 1'b1;
            if (cnt_q == CNT_WIDTH'(ITER_COUNT - 1)) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            fix_en  = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            fin_en  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sign and special-case resolution of the unsigned iteration result
   always_comb begin
      fix_res     = '0;
      fix_res.dz  = dz_q;
      fix_res.ovf = ovf_q;
      if (dz_q) begin
         fix_res.r = dvd_lo_q;
      end else if (ovf_q) begin
         fix_res.q = OVF_QUO;
      end else begin
         fix_res.q = neg_q_q ? DVD_W'(-quo_q) : quo_q;
         fix_res.r = neg_r_q ? DVS_W'(-rem_q[DVS_W-1:0]) : rem_q[DVS_W-1:0];
      end
   end

   // Operand capture and iteration datapath
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_q     <= '0;
         dvd_sh_q  <= '0;
         dvs_mag_q <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvd_lo_q  <= '0;
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
         dz_q      <= 1'b0;
         ovf_q     <= 1'b0;
         res_q     <= '0;
      end else begin
         if (accept) begin
            cnt_q     <= '0;
            dvd_sh_q  <= dvd_mag(DVD_NUM);
            dvs_mag_q <= dvs_mag(DVS_NUM);
            rem_q     <= '0;
            quo_q     <= '0;
            dvd_lo_q  <= DVD_NUM[DVS_W-1:0];
            neg_q_q   <= DVD_NUM[DVD_W-1] ^ DVS_NUM[DVS_W-1];
            neg_r_q   <= DVD_NUM[DVD_W-1];
            dz_q      <= (DVS_NUM == '0);
            ovf_q     <= (DVD_NUM == OVF_DVD) && (DVS_NUM == '1);
         end
         if (calc_en) begin
            cnt_q    <= cnt_q + CNT_WIDTH'(1);
            dvd_sh_q <= {dvd_sh_q[DVD_W-2:0], 1'b0};
            rem_q    <= step_rem;
            quo_q    <= {quo_q[DVD_W-2:0], step_q};
         end
         if (fix_en) begin
            res_q <= fix_res;
         end
      end
   end

   // Output registers: results and flags move only together with done
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         busy  <= 1'b0;
         done  <= 1'b0;
         Q_NUM <= '0;
         R_NUM <= '0;
         dz    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         done <= fin_en;
         if (accept) begin
            busy <= 1'b1;
         end else if (done) begin
            busy <= 1'b0;
         end
         if (fin_en) begin
            Q_NUM <= res_q.q;
            R_NUM <= res_q.r;
            dz    <= res_q.dz;
            ovf   <= res_q.ovf;
         end
      end
   end

endmodule
